axi3_sram_slave: RTL and testbench

- AXI3 slave that terminates the Avalon-to-AXI master bridge's write and read channels into an on-chip byte-enabled SRAM.
- Used as the soft-CPU data/program memory target on the fabric interconnect.
- Independent write and read FSMs.
- Supports FIXED/INCR/WRAP bursts of 1-16 beats, 32-bit data, one outstanding transaction per direction.

---
 rtl/axi3_pkg.sv | 56 +++++
 rtl/sram_dp_be.sv | 31 +++
 rtl/axi3_sram_slave.sv | 208 ++++++++++++++++++++
 tb/tb_axi3_sram_slave.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings, FSM state types and burst address stepping
// for the SRAM slave.
package axi3_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rstate_t;

    function automatic logic req_err(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [3:0] len
    );
        logic wrap_ok;
        wrap_ok = (len == 4'd1) || (len == 4'd3) ||
                  (len == 4'd7) || (len == 4'd15);
        req_err = (size != SIZE_4B) || (burst == 2'b11) ||
                  (burst == BURST_WRAP && !wrap_ok);
    endfunction

    // Word-address step; caller truncates to the memory width,
    // which gives INCR its modulo-depth wrap for free.
    function automatic logic [29:0] next_addr(
        input logic [29:0] addr,
        input logic [3:0]  len,
        input logic [1:0]  burst
    );
        logic [29:0] mask;
        logic [29:0] inc;
        mask = {26'd0, len};
        inc  = addr + 30'd1;
        case (burst)
            BURST_INCR: next_addr = inc;
            BURST_WRAP: next_addr = (addr & ~mask) | (inc & mask);
            default:    next_addr = addr;
        endcase
    endfunction

endpackage

// File: rtl/sram_dp_be.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// A same-address same-cycle access returns the old word.
module sram_dp_be #(
    parameter int    AW        = 10,
    parameter int    DEPTH     = 1 << AW,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[raddr];
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axi3_sram_slave.sv
// AXI3 slave terminating independent write and read channels into
// an on-chip byte-enabled SRAM, one outstanding burst per direction.
module axi3_sram_slave
    import axi3_pkg::*;
#(
    parameter int    ADDR_WIDTH = 12,
    parameter int    ID_WIDTH   = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic [ID_WIDTH-1:0] AWID,
    input  logic [31:0]         AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic [1:0]          AWLOCK,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ID_WIDTH-1:0] WID,
    input  logic [31:0]         WDATA,
    input  logic [3:0]          WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_WIDTH-1:0] BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_WIDTH-1:0] ARID,
    input  logic [31:0]         ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic [1:0]          ARLOCK,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_WIDTH-1:0] RID,
    output logic [31:0]         RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int AW = ADDR_WIDTH - 2;

    wstate_t             w_state;
    logic [ID_WIDTH-1:0] w_id;
    logic [AW-1:0]       w_addr;
    logic [3:0]          w_len;
    logic [3:0]          w_cnt;
    logic [1:0]          w_burst;
    logic                w_err;
    logic                w_fire;
    logic                w_end;
    logic                beat_err;

    rstate_t             r_state;
    logic [ID_WIDTH-1:0] r_id;
    logic [AW-1:0]       r_addr;
    logic [3:0]          r_len;
    logic [3:0]          r_cnt;
    logic [1:0]          r_burst;
    logic                r_err;
    logic [31:0]         ram_q;
    logic                unused_ok;

    assign unused_ok = ^{AWADDR, ARADDR, AWLOCK, ARLOCK};

    assign w_fire   = (w_state == W_DATA) && WVALID && WREADY;
    assign w_end    = WLAST || (w_cnt == w_len);
    // WLAST must coincide exactly with beat LEN, and WID with AWID.
    assign beat_err = (WID != w_id) || (WLAST != (w_cnt == w_len));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= RESP_OKAY;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= BURST_FIXED;
            w_err   <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (AWREADY && AWVALID) begin
                        w_id    <= AWID;
                        w_addr  <= AWADDR[ADDR_WIDTH-1:2];
                        w_len   <= AWLEN;
                        w_burst <= AWBURST;
                        w_cnt   <= '0;
                        w_err   <= req_err(AWSIZE, AWBURST, AWLEN);
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= AW'(next_addr(30'(w_addr), w_len, w_burst));
                        w_cnt  <= w_cnt + 4'd1;
                        w_err  <= w_err | beat_err;
                        if (w_end) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BID     <= w_id;
                            BRESP   <= (w_err | beat_err) ? RESP_SLVERR
                                                          : RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RRESP   <= RESP_OKAY;
            RLAST   <= 1'b0;
            RID     <= '0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= BURST_FIXED;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ARREADY && ARVALID) begin
                        r_id    <= ARID;
                        r_addr  <= ARADDR[ADDR_WIDTH-1:2];
                        r_len   <= ARLEN;
                        r_burst <= ARBURST;
                        r_cnt   <= '0;
                        r_err   <= req_err(ARSIZE, ARBURST, ARLEN);
                        ARREADY <= 1'b0;
                        r_state <= R_FETCH;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                R_FETCH: begin
                    RVALID  <= 1'b1;
                    RID     <= r_id;
                    RRESP   <= r_err ? RESP_SLVERR : RESP_OKAY;
                    RLAST   <= (r_cnt == r_len);
                    r_state <= R_DATA;
                end
                R_DATA: begin
                    if (RREADY) begin
                        RVALID <= 1'b0;
                        RLAST  <= 1'b0;
                        if (RLAST) begin
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr  <= AW'(next_addr(30'(r_addr), r_len, r_burst));
                            r_cnt   <= r_cnt + 4'd1;
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // RAM only reads in R_FETCH, so ram_q holds while RDATA waits on RREADY.
    assign RDATA = (RVALID && !r_err) ? ram_q : 32'd0;

    sram_dp_be #(
        .AW        (AW),
        .DEPTH     (1 << AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (ACLK),
        .we    (w_fire && !(w_err || beat_err)),
        .waddr (w_addr),
        .wdata (WDATA),
        .be    (WSTRB),
        .re    (r_state == R_FETCH),
        .raddr (r_addr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_axi3_sram_slave.sv
// Scoreboard bench for axi3_sram_slave: directed cases plus random
// bursts checked against a word-array reference model.
module tb_axi3_sram_slave;

    localparam int DEPTH = 1024;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  AWID, WID, BID, ARID, RID;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, AWLOCK, ARLOCK, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    axi3_sram_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    bexp_t       bq[$];
    rexp_t       rq[$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int          checks = 0;
    int          failures = 0;
    bit          slow_b = 0;
    bit          slow_r = 0;

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
            if (failures >= 40) begin
                summary();
                $finish;
            end
        end
    endtask

    // Reference rules: illegal size, reserved burst, bad WRAP length.
    function automatic bit bad(input logic [2:0] sz, input logic [1:0] bu,
                               input int len);
        return sz != 3'b010 || bu == 2'b11 ||
               (bu == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic int wa(input logic [31:0] a, input int len,
                              input logic [1:0] bu, input int i);
        int s, n, base;
        s = int'(a[11:2]);
        n = len + 1;
        base = s - (s % n);
        if (bu == 2'b01) return (s + i) % DEPTH;
        if (bu == 2'b10) return base + ((s - base + i) % n);
        return s;
    endfunction

    function automatic logic rdy(input int ch);
        if (ch == 0) return AWREADY;
        if (ch == 1) return WREADY;
        return ARREADY;
    endfunction

    task automatic wait_rdy(input int ch, input string nm);
        int n;
        n = 0;
        @(negedge ACLK);
        while (!rdy(ch) && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk(nm, rdy(ch), 1);
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_drain(input int ch);
        int n;
        n = 0;
        while ((ch == 0 ? bq.size() : rq.size()) != 0 && n < 400) begin
            @(posedge ACLK);
            n++;
        end
        chk(ch == 0 ? "b_drain" : "r_drain",
            ch == 0 ? bq.size() : rq.size(), 0);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input int len, input logic [2:0] sz,
                            input logic [1:0] bu, input int early,
                            input int widbad);
        bit    err;
        int    a, g;
        bexp_t e;
        err = bad(sz, bu, len);
        for (int i = 0; i <= early; i++) begin
            err = err || i == widbad || ((i == early) != (i == len));
            if (!err) begin
                a = wa(addr, len, bu, i);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) mdl[a][b*8 +: 8] = wd[i][b*8 +: 8];
            end
        end
        e.id = id;
        e.resp = err ? 2'b10 : 2'b00;
        bq.push_back(e);
        @(posedge ACLK);
        #1;
        AWID = id; AWADDR = addr; AWLEN = len[3:0]; AWSIZE = sz;
        AWBURST = bu; AWLOCK = 2'($urandom); AWVALID = 1;
        wait_rdy(0, "awready");
        AWVALID = 0;
        for (int i = 0; i <= early; i++) begin
            g = $urandom_range(0, 1);
            repeat (g) begin
                @(posedge ACLK);
                #1;
            end
            WID = (i == widbad) ? id ^ 4'h1 : id;
            WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == early); WVALID = 1;
            wait_rdy(1, "wready");
            WVALID = 0;
            WLAST = 0;
        end
        wait_drain(0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input int len, input logic [2:0] sz,
                           input logic [1:0] bu);
        bit    err;
        rexp_t e;
        err = bad(sz, bu, len);
        for (int i = 0; i <= len; i++) begin
            e.id = id;
            e.data = err ? 32'd0 : mdl[wa(addr, len, bu, i)];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (i == len);
            rq.push_back(e);
        end
        @(posedge ACLK);
        #1;
        ARID = id; ARADDR = addr; ARLEN = len[3:0]; ARSIZE = sz;
        ARBURST = bu; ARLOCK = 2'($urandom); ARVALID = 1;
        wait_rdy(2, "arready");
        ARVALID = 0;
        wait_drain(1);
    endtask

    // Write-response monitor: holds BREADY off, checks stability, pops.
    initial begin : b_mon
        bexp_t      e;
        logic [3:0] id0;
        logic [1:0] r0;
        int         h;
        BREADY = 0;
        forever begin
            @(negedge ACLK);
            if (BVALID && ARESETN) begin
                id0 = BID;
                r0 = BRESP;
                h = slow_b ? 5 : $urandom_range(0, 2);
                repeat (h) begin
                    @(negedge ACLK);
                    chk("b_stable", {BVALID, BID, BRESP}, {1'b1, id0, r0});
                end
                BREADY = 1;
                @(posedge ACLK);
                #1;
                BREADY = 0;
                if (bq.size() == 0) begin
                    chk("b_unexpected", 1, 0);
                end else begin
                    e = bq.pop_front();
                    chk("bid", id0, e.id);
                    chk("bresp", r0, e.resp);
                end
            end
        end
    end

    // Read-data monitor: same idea per beat.
    initial begin : r_mon
        rexp_t       e;
        logic [3:0]  id0;
        logic [31:0] d0;
        logic [1:0]  r0;
        logic        l0;
        int          h;
        RREADY = 0;
        forever begin
            @(negedge ACLK);
            if (RVALID && ARESETN) begin
                id0 = RID; d0 = RDATA; r0 = RRESP; l0 = RLAST;
                h = slow_r ? 1 : $urandom_range(0, 1);
                repeat (h) begin
                    @(negedge ACLK);
                    chk("r_stable", {RVALID, RID, RDATA, RRESP, RLAST},
                        {1'b1, id0, d0, r0, l0});
                end
                RREADY = 1;
                @(posedge ACLK);
                #1;
                RREADY = 0;
                if (rq.size() == 0) begin
                    chk("r_unexpected", 1, 0);
                end else begin
                    e = rq.pop_front();
                    chk("rid", id0, e.id);
                    chk("rdata", d0, e.data);
                    chk("rresp", r0, e.resp);
                    chk("rlast", l0, e.last);
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        chk("watchdog", 0, 1);
        summary();
        $finish;
    end

    initial begin : stim
        logic [31:0] ad;
        logic [1:0]  bu;
        logic [2:0]  sz;
        int          ln, ea, wb;
        ARESETN = 1;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
        AWLOCK = 0; AWVALID = 0; WID = 0; WDATA = 0; WSTRB = 0;
        WLAST = 0; WVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0;
        ARSIZE = 0; ARBURST = 0; ARLOCK = 0; ARVALID = 0;
        #2;
        ARESETN = 0;
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_valids", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}, 0);
        chk("rst_ids_resp", {BID, BRESP, RID, RRESP}, 0);
        chk("rst_rdata", RDATA, 0);
        @(negedge ACLK);
        ARESETN = 1;
        @(posedge ACLK);
        #1;
        chk("ready_after_rst", {AWREADY, ARREADY}, 2'b11);

        // Fill memory with word index.
        for (int blk = 0; blk < DEPTH / 16; blk++) begin
            for (int i = 0; i < 16; i++) begin
                wd[i] = blk * 16 + i;
                ws[i] = 4'hF;
            end
            do_write(4'(blk), 32'(blk * 64), 15, 3'b010, 2'b01, 15, -1);
        end

        do_read(4'h7, 32'h108, 3, 3'b010, 2'b10);

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'h3, 32'h10, 0, 3'b010, 2'b01, 0, -1);
        do_read(4'h5, 32'h10, 0, 3'b010, 2'b01);

        for (int i = 0; i < 4; i++) begin
            wd[i] = i + 1;
            ws[i] = 4'hF;
        end
        do_write(4'h1, 32'h100, 3, 3'b010, 2'b01, 3, -1);
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'h3;
        do_write(4'h2, 32'h104, 0, 3'b010, 2'b01, 0, -1);
        do_read(4'h9, 32'h100, 3, 3'b010, 2'b01);

        wd[0] = 32'h11111111; ws[0] = 4'hF;
        do_write(4'h4, 32'h20, 0, 3'b001, 2'b01, 0, -1);
        do_read(4'h4, 32'h20, 0, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) wd[i] = 32'h5000 + i;
        do_write(4'h6, 32'h30, 3, 3'b010, 2'b01, 1, -1);
        do_read(4'h6, 32'h30, 3, 3'b010, 2'b01);

        slow_b = 1;
        slow_r = 1;
        for (int i = 0; i < 8; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'hF;
        end
        do_write(4'hA, 32'h180, 7, 3'b010, 2'b01, 7, -1);
        do_read(4'hB, 32'h180, 7, 3'b010, 2'b01);
        slow_b = 0;
        slow_r = 0;

        // Reset after the first of four beats.
        @(posedge ACLK);
        #1;
        AWID = 2; AWADDR = 32'h80; AWLEN = 3; AWSIZE = 3'b010;
        AWBURST = 2'b01; AWVALID = 1;
        wait_rdy(0, "awready_rst");
        AWVALID = 0;
        WID = 2; WDATA = 32'hA5A50001; WSTRB = 4'hF; WLAST = 0; WVALID = 1;
        wait_rdy(1, "wready_rst");
        WVALID = 0;
        mdl[32] = 32'hA5A50001;
        #2;
        ARESETN = 0;
        #1;
        chk("midrst_outputs", {AWREADY, WREADY, BVALID, ARREADY, RVALID}, 0);
        @(negedge ACLK);
        ARESETN = 1;
        repeat (2) @(posedge ACLK);
        do_read(4'h2, 32'h80, 3, 3'b010, 2'b01);
        for (int i = 0; i < 2; i++) begin
            wd[i] = 32'hC0DE0000 + i;
            ws[i] = 4'hF;
        end
        do_write(4'hE, 32'h84, 1, 3'b010, 2'b01, 1, -1);
        do_read(4'hE, 32'h80, 3, 3'b010, 2'b01);

        for (int i = 0; i < 8; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'($urandom);
        end
        fork
            do_write(4'h1, 32'h200, 7, 3'b010, 2'b01, 7, -1);
            do_read(4'h2, 32'h300, 7, 3'b010, 2'b01);
        join

        for (int t = 0; t < 80; t++) begin
            ad = $urandom;
            ln = $urandom_range(0, 15);
            bu = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (bu == 2'b10 && $urandom_range(0, 1) == 1)
                ln = (1 << $urandom_range(1, 4)) - 1;
            sz = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    wd[i] = $urandom;
                    ws[i] = 4'($urandom);
                end
                ea = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, ln)) : ln;
                wb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, ln)) : -1;
                do_write(4'($urandom), ad, ln, sz, bu, ea, wb);
            end else begin
                do_read(4'($urandom), ad, ln, sz, bu);
            end
        end

        repeat (5) @(posedge ACLK);
        summary();
        $finish;
    end

endmodule
